dram_sequencer: RTL

Multiplexed-address DRAM controller sitting between the system requesters and the board's 64K x 8 DRAM. It arbitrates between the CPU port, the TED video-fetch port and an internal refresh timer. Each granted access becomes one RAS/CAS cycle: row = addr[7:0] strobed on RAS falling, column = addr[15:8] strobed on CAS falling, with active-low strobes and rw (1 = read, 0 = write). Simulation uses the behavioural RAM model; synthesis drives the physical DRAM pins.

---
 rtl/dram_sequencer_pkg.sv | 33 +++
 rtl/dram_refresh_timer.sv | 47 ++++
 rtl/dram_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dram_sequencer_pkg.sv
// Shared types and default timing for the multiplexed-address DRAM sequencer.
// States, requester IDs and the fixed-priority arbitration helper live here.
package dram_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_RASL,
    ST_COL,
    ST_CASL,
    ST_PRE
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_REF,
    REQ_VID,
    REQ_CPU
  } req_id_t;

  localparam int DEF_REFRESH_INTERVAL = 64;
  localparam int DEF_CAS_CYCLES       = 2;
  localparam int DEF_PRE_CYCLES       = 1;

  // Refresh beats video, video beats CPU.
  function automatic req_id_t arbitrate(input logic ref_pend, input logic vid, input logic cpu);
    if (ref_pend)  return REQ_REF;
    else if (vid)  return REQ_VID;
    else if (cpu)  return REQ_CPU;
    else           return REQ_NONE;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh interval counter, pending/overrun flags and RAS-only row counter.
// Only built when DRAM_SEQUENCER_REFRESH_EN is defined.
`ifdef DRAM_SEQUENCER_REFRESH_EN
module dram_refresh_timer
  import dram_sequencer_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       grant,
  input  logic       row_inc,
  output logic       pending,
  output logic       overrun,
  output logic [7:0] row
);

  localparam int TW = $clog2(REFRESH_INTERVAL);

  logic [TW-1:0] tcnt;
  logic          wrap;

  assign wrap = (tcnt == TW'(REFRESH_INTERVAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt    <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      row     <= '0;
    end else begin
      tcnt <= wrap ? '0 : tcnt + 1'b1;
      // A wrap with an unserved request drops that refresh and leaves a sticky mark.
      if (wrap) begin
        pending <= 1'b1;
        if (pending && !grant)
          overrun <= 1'b1;
      end else if (grant) begin
        pending <= 1'b0;
      end
      if (row_inc)
        row <= row + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/dram_sequencer.sv
// RAS/CAS sequencer arbitrating refresh, video and CPU onto a 64K x 8 DRAM.
// Access is 3 + CAS_CYCLES + PRE_CYCLES cycles; requests wait (held) until ack. Refresh under DRAM_SEQUENCER_REFRESH_EN.
module dram_sequencer
  import dram_sequencer_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int CAS_CYCLES       = DEF_CAS_CYCLES,
  parameter int PRE_CYCLES       = DEF_PRE_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  rdata,
  output logic [7:0]  ram_addr,
  output logic        ram_ras_n,
  output logic        ram_cas_n,
  output logic        ram_rw,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  state_t      state, state_nxt;
  req_id_t     owner, owner_nxt, winner;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] addr_q;
  logic        rw_q;
  logic [7:0]  wdata_q;
  logic        arb, grant, cas_last, pre_last, is_ref, rd_capture;
  logic        ref_pend;
  logic [7:0]  ref_row;

`ifdef DRAM_SEQUENCER_REFRESH_EN
  logic ref_grant, ref_inc, ref_overrun;

  assign ref_grant = grant && (winner == REQ_REF);
  assign ref_inc   = (state == ST_CASL) && cas_last && is_ref;

  dram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .grant   (ref_grant),
    .row_inc (ref_inc),
    .pending (ref_pend),
    .overrun (ref_overrun),
    .row     (ref_row)
  );
`else
  assign ref_pend = 1'b0;
  assign ref_row  = 8'h00;
`endif

  assign winner     = arbitrate(ref_pend, vid_req, cpu_req);
  assign cas_last   = (cnt == 8'(CAS_CYCLES - 1));
  assign pre_last   = (cnt == 8'(PRE_CYCLES - 1));
  assign is_ref     = (owner == REQ_REF);
  assign grant      = arb && (winner != REQ_NONE);
  assign rd_capture = (state == ST_CASL) && cas_last && !is_ref && rw_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      owner   <= REQ_NONE;
      cnt     <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        case (winner)
          REQ_CPU: begin
            addr_q  <= cpu_addr;
            rw_q    <= cpu_rw;
            wdata_q <= cpu_wdata;
          end
          REQ_VID: begin
            addr_q  <= vid_addr;
            rw_q    <= 1'b1;
            wdata_q <= '0;
          end
          default: begin
            rw_q    <= 1'b1;
            wdata_q <= '0;
          end
        endcase
      end
      if (rd_capture)
        rdata <= ram_rdata;
    end
  end

  // Refresh walks the same states as an access so every slot has one length; CAS is masked.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt + 8'd1;
    arb       = 1'b0;
    case (state)
      ST_IDLE: arb = 1'b1;
      ST_ROW: begin
        state_nxt = ST_RASL;
        cnt_nxt   = '0;
      end
      ST_RASL: begin
        state_nxt = ST_COL;
        cnt_nxt   = '0;
      end
      ST_COL: begin
        state_nxt = ST_CASL;
        cnt_nxt   = '0;
      end
      ST_CASL: begin
        if (cas_last) begin
          state_nxt = ST_PRE;
          cnt_nxt   = '0;
        end
      end
      ST_PRE: begin
        if (pre_last)
          arb = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (arb) begin
      owner_nxt = winner;
      cnt_nxt   = '0;
      state_nxt = (winner == REQ_NONE) ? ST_IDLE : ST_ROW;
    end
  end

  always_comb begin
    ram_ras_n = 1'b1;
    ram_cas_n = 1'b1;
    ram_rw    = 1'b1;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      ST_ROW, ST_RASL: begin
        ram_addr  = is_ref ? ref_row : addr_q[7:0];
        ram_ras_n = (state != ST_RASL);
      end
      ST_COL, ST_CASL: begin
        ram_addr  = is_ref ? ref_row : addr_q[15:8];
        ram_ras_n = 1'b0;
        ram_cas_n = is_ref || (state != ST_CASL);
        if (!is_ref && !rw_q) begin
          ram_rw    = 1'b0;
          ram_wdata = wdata_q;
        end
      end
      ST_PRE: ram_addr = is_ref ? ref_row : addr_q[15:8];
      default: ;
    endcase
  end

  assign cpu_ack = (state == ST_PRE) && (cnt == 8'd0) && (owner == REQ_CPU);
  assign vid_ack = (state == ST_PRE) && (cnt == 8'd0) && (owner == REQ_VID);

endmodule
